aquarium_scan_ctrl: RTL and testbench

Scan controller for the aquarium monitor datapath. On request it sequences one pass over the four tank sensor channels (cleanliness, temperature, food storage, saltiness). For each channel it fetches a sample over a request/valid handshake, pulses that channel's register load, and drives the output-mux mode select. It also range-checks each sample, keeps a scan counter for the counter mux input, and forces the mux into error mode (5'b11111) when any channel is out of range or times out.

---
 rtl/aquarium_scan_ctrl.sv | 265 ++++++++++++++++++++++++++
 tb/tb_aquarium_scan_ctrl.sv | 555 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aquarium_scan_ctrl.sv
// ---------------------------------------------------------------------------
// aquarium_scan_ctrl
//
// Scan controller for the aquarium monitor datapath. One scan visits the four
// tank sensor channels in order (0 clean, 1 temp, 2 food, 3 salt). For each
// channel it requests a sample, pulses that channel's register load, and
// holds the output-mux select on the channel's code for DWELL cycles. Each
// sample is range-checked. A channel that is out of range or never answers
// sets a sticky alarm bit. A scan that ends with any alarm set parks the mux
// in error mode (5'b11111) until err_ack.
//
// Parameters:
//   DWELL               cycles the mux select is held per channel (1..15)
//   TIMEOUT             maximum REQ cycles to wait for sense_valid (1..255)
//   CLEAN_LO/CLEAN_HI   cleanliness limits (unsigned, inclusive)
//   TEMP_LO/TEMP_HI     temperature limits
//   FOOD_LO/FOOD_HI     food-storage limits
//   SALT_LO/SALT_HI     saltiness limits
//
// Ports:
//   CLK          in   clock, all logic on the rising edge
//   reset        in   synchronous active-low reset
//   start        in   level scan request, only looked at in IDLE
//   err_ack      in   leaves ERROR and clears the alarm bits
//   sense_valid  in   sample-ready strobe, only looked at in REQ
//   sense_data   in   8-bit sample value
//   sense_req    out  sample request for channel sense_ch
//   sense_ch     out  channel being scanned
//   reg_load     out  one-hot single-cycle channel register load
//   load_data    out  last accepted sample
//   mux_select   out  output-mux mode select
//   scan_count   out  completed-scan counter (wraps at 256)
//   alarm        out  sticky per-channel out-of-range/timeout flags
//   busy         out  high in every state except IDLE
//   done         out  one-cycle pulse on a clean scan completion
//   error        out  high while in ERROR
//
// Build option:
//   AQ_AUTO_SCAN_EN  when defined, a clean scan restarts immediately without
//                    waiting for start; otherwise every scan needs start.
// ---------------------------------------------------------------------------
module aquarium_scan_ctrl #(
  parameter int unsigned DWELL    = 4,
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [7:0]  CLEAN_LO = 8'd32,
  parameter logic [7:0]  CLEAN_HI = 8'd255,
  parameter logic [7:0]  TEMP_LO  = 8'd20,
  parameter logic [7:0]  TEMP_HI  = 8'd30,
  parameter logic [7:0]  FOOD_LO  = 8'd16,
  parameter logic [7:0]  FOOD_HI  = 8'd255,
  parameter logic [7:0]  SALT_LO  = 8'd30,
  parameter logic [7:0]  SALT_HI  = 8'd40
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic       err_ack,
  input  logic       sense_valid,
  input  logic [7:0] sense_data,
  output logic       sense_req,
  output logic [1:0] sense_ch,
  output logic [3:0] reg_load,
  output logic [7:0] load_data,
  output logic [4:0] mux_select,
  output logic [7:0] scan_count,
  output logic [3:0] alarm,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_REQ   = 3'd2;
  localparam logic [2:0] ST_LOAD  = 3'd3;
  localparam logic [2:0] ST_DWELL = 3'd4;
  localparam logic [2:0] ST_CHECK = 3'd5;
  localparam logic [2:0] ST_ERROR = 3'd6;

  // Terminal values of the shared cycle counter in REQ and DWELL.
  localparam logic [7:0] DWELL_LAST   = 8'(DWELL - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  localparam logic [4:0] MUX_IDLE  = 5'b00000;
  localparam logic [4:0] MUX_COUNT = 5'b00001;
  localparam logic [4:0] MUX_ERROR = 5'b11111;

  logic [2:0] state;
  logic [2:0] next_state;
  logic [1:0] index;
  logic [7:0] cnt;
  logic [7:0] lo_lim;
  logic [7:0] hi_lim;
  logic       capture;
  logic       timed_out;
  logic       dwell_end;
  logic       out_of_range;
  logic [3:0] ch_onehot;
  logic [4:0] ch_mux_code;

  // Limits of the channel currently being scanned.
  always_comb begin
    lo_lim = CLEAN_LO;
    hi_lim = CLEAN_HI;
    case (index)
      2'd0: begin
        lo_lim = CLEAN_LO;
        hi_lim = CLEAN_HI;
      end
      2'd1: begin
        lo_lim = TEMP_LO;
        hi_lim = TEMP_HI;
      end
      2'd2: begin
        lo_lim = FOOD_LO;
        hi_lim = FOOD_HI;
      end
      default: begin
        lo_lim = SALT_LO;
        hi_lim = SALT_HI;
      end
    endcase
  end

  // A valid sample on the last permitted REQ cycle still counts as a
  // capture, so the timeout only fires when sense_valid is low.
  assign capture      = (state == ST_REQ) && sense_valid;
  assign timed_out    = (state == ST_REQ) && !sense_valid && (cnt == TIMEOUT_LAST);
  assign dwell_end    = (state == ST_DWELL) && (cnt == DWELL_LAST);
  assign out_of_range = (sense_data < lo_lim) || (sense_data > hi_lim);
  assign ch_onehot    = 4'b0001 << index;
  assign ch_mux_code  = 5'b00010 << index;
  assign sense_ch     = index;

  // Next-state decode of the scan sequencer.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) next_state = ST_COUNT;
      end
      ST_COUNT: begin
        next_state = ST_REQ;
      end
      ST_REQ: begin
        if (capture)        next_state = ST_LOAD;
        else if (timed_out) next_state = ST_DWELL;
      end
      ST_LOAD: begin
        next_state = ST_DWELL;
      end
      ST_DWELL: begin
        if (dwell_end) next_state = (index == 2'd3) ? ST_CHECK : ST_REQ;
      end
      ST_CHECK: begin
        if (alarm != 4'b0000) begin
          next_state = ST_ERROR;
        end else begin
`ifdef AQ_AUTO_SCAN_EN
          next_state = ST_COUNT;
`else
          next_state = ST_IDLE;
`endif
        end
      end
      ST_ERROR: begin
        if (err_ack) next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // State register plus the per-state cycle counter. The counter restarts on
  // every state change, so it measures REQ wait time and DWELL hold time.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        cnt <= 8'd0;
      end else if ((state == ST_REQ) || (state == ST_DWELL)) begin
        cnt <= cnt + 8'd1;
      end else begin
        cnt <= 8'd0;
      end
    end
  end

  // Channel index: cleared on the way into COUNT, advanced when a non-final
  // channel finishes its dwell so the next REQ already sees the new channel.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      index <= 2'd0;
    end else if (next_state == ST_COUNT) begin
      index <= 2'd0;
    end else if (dwell_end && (index != 2'd3)) begin
      index <= index + 2'd1;
    end
  end

  // Sample capture and sticky alarm bits. Out-of-range samples are still
  // passed on to the channel register; only the alarm records the fault.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      load_data <= 8'd0;
      alarm     <= 4'b0000;
    end else begin
      if (capture) load_data <= sense_data;
      if ((state == ST_ERROR) && err_ack) begin
        alarm <= 4'b0000;
      end else if ((capture && out_of_range) || timed_out) begin
        alarm <= alarm | ch_onehot;
      end
    end
  end

  // Completed-scan counter, bumped in CHECK whether or not the scan was clean.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      scan_count <= 8'd0;
    end else if (state == ST_CHECK) begin
      scan_count <= scan_count + 8'd1;
    end
  end

  // Status and strobe outputs are decoded from the state being entered, so
  // each flop shows the value belonging to the state it will sit alongside.
  // done is raised on entry to CHECK; alarm is already final by then.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      sense_req <= 1'b0;
      reg_load  <= 4'b0000;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      sense_req <= (next_state == ST_REQ);
      reg_load  <= (next_state == ST_LOAD) ? ch_onehot : 4'b0000;
      busy      <= (next_state != ST_IDLE);
      done      <= (next_state == ST_CHECK) && (alarm == 4'b0000);
      error     <= (next_state == ST_ERROR);
    end
  end

  // Mux select only changes on entry to IDLE, COUNT, DWELL or ERROR; through
  // REQ, LOAD and CHECK it keeps showing the previous mode.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      mux_select <= MUX_IDLE;
    end else begin
      case (next_state)
        ST_IDLE:  mux_select <= MUX_IDLE;
        ST_COUNT: mux_select <= MUX_COUNT;
        ST_DWELL: mux_select <= ch_mux_code;
        ST_ERROR: mux_select <= MUX_ERROR;
        default:  mux_select <= mux_select;
      endcase
    end
  end

endmodule

// File: tb/tb_aquarium_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aquarium_scan_ctrl
//
// Self-checking bench for aquarium_scan_ctrl. A scan is described by a
// per-channel sample value and a per-channel response latency (REQ cycles
// before sense_valid, or "never"). The expected loads, alarm bits, mux mode
// sequence, done position and scan count are worked out from those numbers
// and the channel limits, then compared with what the DUT produces.
// ---------------------------------------------------------------------------
module tb_aquarium_scan_ctrl;

  localparam int DWELL   = 4;
  localparam int TIMEOUT = 16;
  localparam int NEVER   = 999;

`ifdef AQ_AUTO_SCAN_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       CLK;
  logic       reset;
  logic       start;
  logic       err_ack;
  logic       sense_valid;
  logic [7:0] sense_data;
  logic       sense_req;
  logic [1:0] sense_ch;
  logic [3:0] reg_load;
  logic [7:0] load_data;
  logic [4:0] mux_select;
  logic [7:0] scan_count;
  logic [3:0] alarm;
  logic       busy;
  logic       done;
  logic       error;

  int total = 0;
  int bad   = 0;

  int         scan_lat[4];
  logic [7:0] scan_vals[4];
  logic [7:0] model_count;

  aquarium_scan_ctrl #(
    .DWELL   (DWELL),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .start       (start),
    .err_ack     (err_ack),
    .sense_valid (sense_valid),
    .sense_data  (sense_data),
    .sense_req   (sense_req),
    .sense_ch    (sense_ch),
    .reg_load    (reg_load),
    .load_data   (load_data),
    .mux_select  (mux_select),
    .scan_count  (scan_count),
    .alarm       (alarm),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  // 100 MHz-style free-running clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Hard stop in case the DUT wedges somewhere no bounded wait covers.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got=still running exp=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] lim_lo(input int ch);
    case (ch)
      0:       return 8'd32;
      1:       return 8'd20;
      2:       return 8'd16;
      default: return 8'd30;
    endcase
  endfunction

  function automatic logic [7:0] lim_hi(input int ch);
    case (ch)
      0:       return 8'd255;
      1:       return 8'd30;
      2:       return 8'd255;
      default: return 8'd40;
    endcase
  endfunction

  function automatic bit in_range(input int ch, input logic [7:0] v);
    return (v >= lim_lo(ch)) && (v <= lim_hi(ch));
  endfunction

  function automatic logic [7:0] good_val(input int ch);
    case (ch)
      0:       return 8'd64;
      1:       return 8'd25;
      2:       return 8'd100;
      default: return 8'd35;
    endcase
  endfunction

  function automatic logic [7:0] rand_in_range(input int ch);
    int span;
    span = int'(lim_hi(ch)) - int'(lim_lo(ch)) + 1;
    return 8'(int'(lim_lo(ch)) + int'($urandom_range(0, span - 1)));
  endfunction

  task automatic do_reset();
    start       = 1'b0;
    err_ack     = 1'b0;
    sense_valid = 1'b0;
    sense_data  = 8'd0;
    reset       = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset       = 1'b1;
    model_count = 8'd0;
  endtask

  // One scan from IDLE. Inputs outside REQ (and err_ack/start while busy)
  // are driven with noise that the DUT must ignore.
  task automatic run_scan(output bit had_error);
    int         exp_loads[$];
    logic [4:0] exp_mux[$];
    logic [4:0] seen_mux[$];
    logic [3:0] exp_alarm;
    logic [4:0] prev_mux;
    logic [4:0] exp_code;
    int         n_chk;
    int         got_loads;
    int         episodes;
    int         k;
    int         ch;
    int         c;
    int         done_cnt;
    int         done_at;
    bit         in_req;
    bit         busy_ok;
    bit         mux_pending;
    bit         seq_ok;
    bit         clean;

    exp_alarm = 4'b0000;
    n_chk     = 2;
    exp_mux.push_back(5'b00001);
    for (int i = 0; i < 4; i++) begin
      exp_mux.push_back(5'(2 << i));
      if (scan_lat[i] >= TIMEOUT) begin
        exp_alarm[i] = 1'b1;
        n_chk += TIMEOUT + DWELL;
      end else begin
        exp_loads.push_back(i);
        if (!in_range(i, scan_vals[i])) exp_alarm[i] = 1'b1;
        n_chk += scan_lat[i] + 2 + DWELL;
      end
    end
    clean = (exp_alarm == 4'b0000);
    exp_mux.push_back(!clean ? 5'b11111 : (AUTO ? 5'b00001 : 5'b00000));
    had_error   = !clean;
    model_count = model_count + 8'd1;

    prev_mux    = 5'b00000;
    exp_code    = 5'b00000;
    got_loads   = 0;
    episodes    = 0;
    k           = 0;
    ch          = 0;
    done_cnt    = 0;
    done_at     = -1;
    in_req      = 1'b0;
    busy_ok     = 1'b1;
    mux_pending = 1'b0;

    @(negedge CLK);
    start       = 1'b1;
    err_ack     = 1'b0;
    sense_valid = 1'b0;

    for (int n = 1; n <= n_chk + 1; n++) begin
      @(negedge CLK);
      if (mux_select !== prev_mux) begin
        seen_mux.push_back(mux_select);
        prev_mux = mux_select;
      end
      if (mux_pending) begin
        total++;
        if (mux_select !== exp_code) begin
          bad++;
          $display("[TB] FAIL mux_after_load: got=%b exp=%b at n=%0d", mux_select, exp_code, n);
        end
        mux_pending = 1'b0;
      end
      if (reg_load !== 4'b0000) begin
        total++;
        if (got_loads >= exp_loads.size()) begin
          bad++;
          $display("[TB] FAIL extra_load: got=%b exp=0000 at n=%0d", reg_load, n);
        end else begin
          c = exp_loads[got_loads];
          if (reg_load !== 4'(1 << c) || load_data !== scan_vals[c]) begin
            bad++;
            $display("[TB] FAIL load: got=%b/%0d exp=%b/%0d", reg_load, load_data,
                     4'(1 << c), scan_vals[c]);
          end
          exp_code    = 5'(2 << c);
          mux_pending = 1'b1;
        end
        got_loads++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_at = n;
      end
      if (n <= n_chk && busy !== 1'b1) busy_ok = 1'b0;

      if (sense_req === 1'b1) begin
        if (!in_req) begin
          episodes++;
          ch     = (episodes > 4) ? 3 : episodes - 1;
          k      = 0;
          in_req = 1'b1;
          total++;
          if (sense_ch !== 2'(ch)) begin
            bad++;
            $display("[TB] FAIL sense_ch: got=%0d exp=%0d", sense_ch, ch);
          end
        end else begin
          k++;
        end
        sense_valid = (k == scan_lat[ch]);
        sense_data  = sense_valid ? scan_vals[ch] : 8'($urandom);
      end else begin
        in_req      = 1'b0;
        sense_valid = 1'($urandom_range(0, 1));
        sense_data  = 8'($urandom);
      end
      start   = (n <= n_chk) ? 1'($urandom_range(0, 1)) : 1'b0;
      err_ack = (n <= n_chk) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start       = 1'b0;
    err_ack     = 1'b0;
    sense_valid = 1'b0;

    total++;
    if (got_loads != exp_loads.size()) begin
      bad++;
      $display("[TB] FAIL load_count: got=%0d exp=%0d", got_loads, exp_loads.size());
    end
    total++;
    if (episodes != 4) begin
      bad++;
      $display("[TB] FAIL req_count: got=%0d exp=4", episodes);
    end
    total++;
    if (done_cnt != (clean ? 1 : 0) || (clean && done_at != n_chk)) begin
      bad++;
      $display("[TB] FAIL done: got=%0d pulses at n=%0d exp=%0d at n=%0d", done_cnt, done_at,
               clean ? 1 : 0, n_chk);
    end
    total++;
    if (!busy_ok) begin
      bad++;
      $display("[TB] FAIL busy_during_scan: got=low exp=high");
    end
    total++;
    if (busy !== (had_error || AUTO)) begin
      bad++;
      $display("[TB] FAIL busy_after: got=%b exp=%b", busy, had_error || AUTO);
    end
    total++;
    if (error !== had_error) begin
      bad++;
      $display("[TB] FAIL error: got=%b exp=%b", error, had_error);
    end
    total++;
    if (alarm !== exp_alarm) begin
      bad++;
      $display("[TB] FAIL alarm: got=%b exp=%b", alarm, exp_alarm);
    end
    total++;
    if (scan_count !== model_count) begin
      bad++;
      $display("[TB] FAIL scan_count: got=%0d exp=%0d", scan_count, model_count);
    end
    seq_ok = (seen_mux.size() == exp_mux.size());
    for (int i = 0; i < seen_mux.size() && seq_ok; i++) begin
      if (seen_mux[i] !== exp_mux[i]) seq_ok = 1'b0;
    end
    total++;
    if (!seq_ok) begin
      bad++;
      $display("[TB] FAIL mux_sequence: got %0d modes, last=%b exp %0d modes, last=%b",
               seen_mux.size(), prev_mux, exp_mux.size(), exp_mux[exp_mux.size() - 1]);
    end
  endtask

  // ERROR must ignore start and hold the error mux mode until err_ack.
  task automatic clear_error();
    bit stay_ok;
    stay_ok = 1'b1;
    start   = 1'b1;
    err_ack = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (error !== 1'b1 || mux_select !== 5'b11111 || busy !== 1'b1) stay_ok = 1'b0;
    end
    total++;
    if (!stay_ok) begin
      bad++;
      $display("[TB] FAIL error_hold: got=err%b mux=%b exp=err1 mux=11111", error, mux_select);
    end
    start   = 1'b0;
    err_ack = 1'b1;
    @(negedge CLK);
    err_ack = 1'b0;
    total++;
    if ({error, busy, alarm, mux_select} !== 11'd0) begin
      bad++;
      $display("[TB] FAIL err_ack: got=err%b busy%b alarm=%b mux=%b exp=all zero",
               error, busy, alarm, mux_select);
    end
  endtask

  task automatic settle(input bit had_error);
    if (had_error)  clear_error();
    else if (AUTO)  do_reset();
  endtask

  task automatic set_scan(input int l0, input int l1, input int l2, input int l3,
                          input logic [7:0] v0, input logic [7:0] v1,
                          input logic [7:0] v2, input logic [7:0] v3);
    scan_lat[0]  = l0;
    scan_lat[1]  = l1;
    scan_lat[2]  = l2;
    scan_lat[3]  = l3;
    scan_vals[0] = v0;
    scan_vals[1] = v1;
    scan_vals[2] = v2;
    scan_vals[3] = v3;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({sense_req, sense_ch, reg_load, load_data, mux_select, scan_count, alarm,
         busy, done, error} !== 35'd0) begin
      bad++;
      $display("[TB] FAIL reset_values: got=req%b ch%0d ld%b data%0d mux%b cnt%0d alarm%b busy%b done%b err%b exp=all zero",
               sense_req, sense_ch, reg_load, load_data, mux_select, scan_count, alarm,
               busy, done, error);
    end
    repeat (3) @(negedge CLK);
    total++;
    if ({busy, sense_req, mux_select} !== 7'd0) begin
      bad++;
      $display("[TB] FAIL idle_hold: got=busy%b req%b mux%b exp=0", busy, sense_req, mux_select);
    end
  endtask

  task automatic test_clean_scan();
    bit e;
    do_reset();
    set_scan(1, 1, 1, 1, 8'd64, 8'd25, 8'd100, 8'd35);
    run_scan(e);
    settle(e);
    set_scan(0, 0, 0, 0, 8'd64, 8'd25, 8'd100, 8'd35);
    run_scan(e);
    settle(e);
  endtask

  task automatic test_out_of_range();
    bit e;
    do_reset();
    set_scan(1, 1, 1, 1, 8'd64, 8'd31, 8'd100, 8'd35);
    run_scan(e);
    settle(e);
  endtask

  task automatic test_timeout();
    bit e;
    do_reset();
    set_scan(1, 1, NEVER, 1, 8'd64, 8'd25, 8'd100, 8'd35);
    run_scan(e);
    settle(e);
    set_scan(TIMEOUT - 1, 2, TIMEOUT - 1, 0, 8'd32, 8'd20, 8'd16, 8'd40);
    run_scan(e);
    settle(e);
  endtask

  task automatic test_random();
    bit e;
    int r;
    do_reset();
    for (int it = 0; it < 30; it++) begin
      for (int c = 0; c < 4; c++) begin
        r = int'($urandom_range(0, 9));
        scan_lat[c] = (r == 0) ? NEVER : (r == 1) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
        r = int'($urandom_range(0, 7));
        case (r)
          0:       scan_vals[c] = lim_lo(c) - 8'd1;
          1:       scan_vals[c] = lim_lo(c);
          2:       scan_vals[c] = lim_hi(c);
          3:       scan_vals[c] = lim_hi(c) + 8'd1;
          4:       scan_vals[c] = 8'($urandom);
          default: scan_vals[c] = rand_in_range(c);
        endcase
      end
      run_scan(e);
      settle(e);
    end
  endtask

  task automatic test_mid_scan_reset();
    bit e;
    bit hit;
    do_reset();
    set_scan(0, 0, 0, 0, 8'd64, 8'd25, 8'd100, 8'd35);
    run_scan(e);
    settle(e);
    hit = 1'b0;
    @(negedge CLK);
    start = 1'b1;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge CLK);
      start       = 1'b0;
      sense_valid = sense_req;
      sense_data  = good_val(int'(sense_ch));
      if (mux_select === 5'b00100) hit = 1'b1;
    end
    total++;
    if (!hit) begin
      bad++;
      $display("[TB] FAIL reach_temp_dwell: got=not reached exp=mux 00100 within 200 cycles");
    end
    reset       = 1'b0;
    sense_valid = 1'b0;
    @(negedge CLK);
    total++;
    if ({sense_req, sense_ch, reg_load, load_data, mux_select, scan_count, alarm,
         busy, done, error} !== 35'd0) begin
      bad++;
      $display("[TB] FAIL mid_scan_reset: got=req%b ch%0d mux%b cnt%0d busy%b exp=all zero",
               sense_req, sense_ch, mux_select, scan_count, busy);
    end
    reset       = 1'b1;
    model_count = 8'd0;
    repeat (2) @(negedge CLK);
    total++;
    if ({busy, sense_req, mux_select} !== 7'd0) begin
      bad++;
      $display("[TB] FAIL idle_after_reset: got=busy%b req%b mux%b exp=0", busy, sense_req, mux_select);
    end
  endtask

`ifdef AQ_AUTO_SCAN_EN
  task automatic test_auto_scan();
    int  done_cnt;
    bit  busy_ok;
    do_reset();
    done_cnt = 0;
    busy_ok  = 1'b1;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      sense_valid = sense_req;
      sense_data  = good_val(int'(sense_ch));
      @(negedge CLK);
      if (done === 1'b1) done_cnt++;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    sense_valid = 1'b0;
    total++;
    if (done_cnt < 3 || !busy_ok) begin
      bad++;
      $display("[TB] FAIL auto_scan: got=%0d done busy_ok=%b exp=>=3 done busy_ok=1", done_cnt, busy_ok);
    end
    do_reset();
  endtask
`else
  task automatic test_no_auto();
    bit e;
    bit quiet;
    do_reset();
    set_scan(0, 1, 2, 3, 8'd200, 8'd22, 8'd17, 8'd39);
    run_scan(e);
    settle(e);
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sense_valid = 1'($urandom_range(0, 1));
      @(negedge CLK);
      if (done !== 1'b0 || busy !== 1'b0 || sense_req !== 1'b0) quiet = 1'b0;
    end
    sense_valid = 1'b0;
    total++;
    if (!quiet) begin
      bad++;
      $display("[TB] FAIL no_restart: got=activity without start exp=idle");
    end
  endtask

  task automatic test_counter_wrap();
    bit e;
    do_reset();
    for (int s = 0; s < 256; s++) begin
      for (int c = 0; c < 4; c++) begin
        scan_lat[c]  = int'($urandom_range(0, 2));
        scan_vals[c] = rand_in_range(c);
      end
      run_scan(e);
      settle(e);
    end
    total++;
    if (scan_count !== 8'd0) begin
      bad++;
      $display("[TB] FAIL counter_wrap: got=%0d exp=0", scan_count);
    end
  endtask
`endif

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    err_ack     = 1'b0;
    sense_valid = 1'b0;
    sense_data  = 8'd0;
    model_count = 8'd0;
    test_reset();
    test_clean_scan();
    test_out_of_range();
    test_timeout();
    test_random();
    test_mid_scan_reset();
`ifdef AQ_AUTO_SCAN_EN
    test_auto_scan();
`else
    test_no_auto();
    test_counter_wrap();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
